// File: rtl/controller_pkg.sv
// Shared types for the NES controller reader: FSM state encoding and the
// bit position of each button in the published button bytes.
package controller_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LATCH,
    GAP,
    PULSE,
    COMMIT
  } controller_state_t;

  // Pads shift A first; it lands in the MSB of the byte.
  localparam int BTN_A      = 7;
  localparam int BTN_B      = 6;
  localparam int BTN_SELECT = 5;
  localparam int BTN_START  = 4;
  localparam int BTN_UP     = 3;
  localparam int BTN_DOWN   = 2;
  localparam int BTN_LEFT   = 1;
  localparam int BTN_RIGHT  = 0;

endpackage

// File: rtl/controller_shift_m.sv
// One pad's serial-in shift register. Captures the raw active-low serial
// bit MSB-first on each sample enable; cleared at the start of a poll.
module controller_shift_m #(
  parameter int NUM_BUTTONS = 8
) (
  input  logic                   clk_1,
  input  logic                   rst,
  input  logic                   clear,
  input  logic                   sample_en,
  input  logic                   serial_bit,
  output logic [NUM_BUTTONS-1:0] shift_out
);

  // Shift the sampled bit in at the LSB so the first bit ends up at the MSB.
  always_ff @(posedge clk_1 or posedge rst) begin
    if (rst) begin
      shift_out <= '0;
    end else if (clear) begin
      shift_out <= '0;
    end else if (sample_en) begin
      shift_out <= {shift_out[NUM_BUTTONS-2:0], serial_bit};
    end
  end

endmodule

// File: rtl/controller_reader_m.sv
// Serial front end for two NES-style pads: drives the shared latch and
// shift clock, shifts in both active-low data lines and publishes two
// registered active-high button bytes.
// Optional: define CONTROLLER_READER_AUTOPOLL_EN to add a free-running
// poll timer (every POLL_PERIOD cycles) ORed with start_poll.
module controller_reader_m
  import controller_pkg::*;
#(
  parameter int NUM_BUTTONS  = 8,
  parameter int LATCH_CYCLES = 2,
  parameter int HALF_PERIOD  = 2,
  parameter int POLL_PERIOD  = 16667
) (
  input  logic                   clk_1,
  input  logic                   rst,
  input  logic                   start_poll,
  input  logic                   controller_1_data_in_B,
  input  logic                   controller_2_data_in_B,
  output logic                   controller_latch,
  output logic                   controller_clk_in,
  output logic                   controller_clk_out_enable,
  output logic                   busy,
  output logic                   buttons_valid,
  output logic [NUM_BUTTONS-1:0] controller_1_buttons_out,
  output logic [NUM_BUTTONS-1:0] controller_2_buttons_out
);

  localparam int CNT_MAX = (LATCH_CYCLES > HALF_PERIOD) ? LATCH_CYCLES : HALF_PERIOD;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int IDX_W   = (NUM_BUTTONS > 1) ? $clog2(NUM_BUTTONS) : 1;

  // Empty on purpose: a landing spot for out-of-range parameter sets.
  if (NUM_BUTTONS < 2 || LATCH_CYCLES < 1 || HALF_PERIOD < 1 || POLL_PERIOD < 1) begin : g_param_out_of_range
  end

  controller_state_t       state;
  logic [CNT_W-1:0]        cnt;
  logic [IDX_W-1:0]        idx;
  logic                    auto_req;
  logic                    poll_req;
  logic                    sample_en;
  logic                    clear_sr;
  logic [NUM_BUTTONS-1:0]  shift_1;
  logic [NUM_BUTTONS-1:0]  shift_2;

`ifdef CONTROLLER_READER_AUTOPOLL_EN
  localparam int POLL_W = (POLL_PERIOD > 1) ? $clog2(POLL_PERIOD) : 1;

  logic [POLL_W-1:0] poll_cnt;

  // Free-running poll timer; keeps counting through polls so the cadence is fixed.
  always_ff @(posedge clk_1 or posedge rst) begin
    if (rst) begin
      poll_cnt <= '0;
    end else if (poll_cnt == POLL_W'(POLL_PERIOD - 1)) begin
      poll_cnt <= '0;
    end else begin
      poll_cnt <= poll_cnt + POLL_W'(1);
    end
  end

  assign auto_req = (poll_cnt == POLL_W'(POLL_PERIOD - 1));
`else
  assign auto_req = 1'b0;
`endif

  assign poll_req  = start_poll | auto_req;
  assign clear_sr  = (state == IDLE) && poll_req;
  assign sample_en = (state == GAP) && (cnt == CNT_W'(HALF_PERIOD - 1));

  controller_shift_m #(.NUM_BUTTONS(NUM_BUTTONS)) u_shift_1 (
    .clk_1      (clk_1),
    .rst        (rst),
    .clear      (clear_sr),
    .sample_en  (sample_en),
    .serial_bit (controller_1_data_in_B),
    .shift_out  (shift_1)
  );

  controller_shift_m #(.NUM_BUTTONS(NUM_BUTTONS)) u_shift_2 (
    .clk_1      (clk_1),
    .rst        (rst),
    .clear      (clear_sr),
    .sample_en  (sample_en),
    .serial_bit (controller_2_data_in_B),
    .shift_out  (shift_2)
  );

  // Poll sequencer. Pin outputs are registered decodes of the current state,
  // so they trail the state by one cycle; sampling happens at the end of each
  // GAP, by which point the pin clock has been low for HALF_PERIOD-1 cycles.
  always_ff @(posedge clk_1 or posedge rst) begin
    if (rst) begin
      state                     <= IDLE;
      cnt                       <= '0;
      idx                       <= '0;
      controller_latch          <= 1'b0;
      controller_clk_in         <= 1'b0;
      controller_clk_out_enable <= 1'b0;
      busy                      <= 1'b0;
      buttons_valid             <= 1'b0;
      controller_1_buttons_out  <= '0;
      controller_2_buttons_out  <= '0;
    end else begin
      controller_latch          <= (state == LATCH);
      controller_clk_in         <= (state == PULSE);
      busy                      <= (state == LATCH) || (state == GAP) || (state == PULSE);
      controller_clk_out_enable <= (state == LATCH) || (state == GAP) || (state == PULSE);
      buttons_valid             <= (state == COMMIT);

      case (state)
        IDLE: begin
          cnt <= '0;
          idx <= '0;
          if (poll_req) begin
            state <= LATCH;
          end
        end
        LATCH: begin
          if (cnt == CNT_W'(LATCH_CYCLES - 1)) begin
            cnt   <= '0;
            idx   <= '0;
            state <= GAP;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        GAP: begin
          if (cnt == CNT_W'(HALF_PERIOD - 1)) begin
            cnt <= '0;
            if (idx == IDX_W'(NUM_BUTTONS - 1)) begin
              state <= COMMIT;
            end else begin
              state <= PULSE;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        PULSE: begin
          if (cnt == CNT_W'(HALF_PERIOD - 1)) begin
            cnt   <= '0;
            idx   <= idx + IDX_W'(1);
            state <= GAP;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        COMMIT: begin
          controller_1_buttons_out <= ~shift_1;
          controller_2_buttons_out <= ~shift_2;
          state                    <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_controller_reader_m.sv
// Directed bench for controller_reader_m with behavioural 4021-style pads.
module tb_controller_reader_m;
  import controller_pkg::*;

  logic       clk_1 = 1'b0;
  logic       rst = 1'b1;
  logic       start_poll = 1'b0;
  logic       controller_1_data_in_B;
  logic       controller_2_data_in_B;
  logic       controller_latch;
  logic       controller_clk_in;
  logic       controller_clk_out_enable;
  logic       busy;
  logic       buttons_valid;
  logic [7:0] controller_1_buttons_out;
  logic [7:0] controller_2_buttons_out;

  logic [7:0] pad1_btn = 8'h00;
  logic [7:0] pad2_btn = 8'h00;
  logic [7:0] pad1_sr = 8'hFF;
  logic [7:0] pad2_sr = 8'hFF;
  logic       pads_connected = 1'b1;

  int checks = 0;
  int fails  = 0;

  controller_reader_m #(
    .NUM_BUTTONS  (8),
    .LATCH_CYCLES (2),
    .HALF_PERIOD  (2),
    .POLL_PERIOD  (100)
  ) dut (
    .clk_1                     (clk_1),
    .rst                       (rst),
    .start_poll                (start_poll),
    .controller_1_data_in_B    (controller_1_data_in_B),
    .controller_2_data_in_B    (controller_2_data_in_B),
    .controller_latch          (controller_latch),
    .controller_clk_in         (controller_clk_in),
    .controller_clk_out_enable (controller_clk_out_enable),
    .busy                      (busy),
    .buttons_valid             (buttons_valid),
    .controller_1_buttons_out  (controller_1_buttons_out),
    .controller_2_buttons_out  (controller_2_buttons_out)
  );

  always #5 clk_1 = ~clk_1;

  // Pad model: parallel load while latch is high, shift on rising clock, 1s fill.
  always @(posedge controller_latch or posedge controller_clk_in) begin
    if (controller_latch) begin
      pad1_sr <= ~pad1_btn;
      pad2_sr <= ~pad2_btn;
    end else begin
      pad1_sr <= {pad1_sr[6:0], 1'b1};
      pad2_sr <= {pad2_sr[6:0], 1'b1};
    end
  end

  assign controller_1_data_in_B = pads_connected ? pad1_sr[7] : 1'b1;
  assign controller_2_data_in_B = pads_connected ? pad2_sr[7] : 1'b1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called #1 after a clock edge; start_poll is sampled at the next edge (edge 0).
  task automatic run_poll(input int extra_at, output int valid_edge, output int valid_cnt,
                          output int latch_cycles, output int clk_pulses,
                          output int clk_high, output int busy_first);
    logic prev_clk;
    valid_edge = -1; valid_cnt = 0; latch_cycles = 0;
    clk_pulses = 0; clk_high = 0; busy_first = -1; prev_clk = 1'b0;
    start_poll = 1'b1;
    @(posedge clk_1); #1;
    start_poll = 1'b0;
    for (int k = 1; k <= 45; k++) begin
      if (k == extra_at) start_poll = 1'b1;
      @(posedge clk_1); #1;
      if (k == extra_at) start_poll = 1'b0;
      if (buttons_valid) begin
        valid_cnt++;
        if (valid_edge < 0) valid_edge = k;
      end
      if (busy && busy_first < 0) busy_first = k;
      if (controller_latch) latch_cycles++;
      if (controller_clk_in) clk_high++;
      if (controller_clk_in && !prev_clk) clk_pulses++;
      prev_clk = controller_clk_in;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int ve, vc, lc, cp, ch, bf;
    int lat_seen, clk_seen;

    // Reset held for two cycles.
    repeat (2) @(posedge clk_1);
    #1;
    check_eq("rst_latch", controller_latch, 0);
    check_eq("rst_clk", controller_clk_in, 0);
    check_eq("rst_en", controller_clk_out_enable, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_valid", buttons_valid, 0);
    check_eq("rst_btn1", controller_1_buttons_out, 0);
    check_eq("rst_btn2", controller_2_buttons_out, 0);
    rst = 1'b0;

`ifdef CONTROLLER_READER_AUTOPOLL_EN
    begin
      int edges[$];
      int cyc;
      bit issued;
      pad1_btn = 8'((1 << BTN_A) | (1 << BTN_RIGHT));
      pad2_btn = 8'((1 << BTN_B) | (1 << BTN_START) | (1 << BTN_UP) | (1 << BTN_LEFT));
      cyc = 0; issued = 1'b0;
      for (int k = 0; k < 600; k++) begin
        @(posedge clk_1); #1;
        cyc++;
        if (start_poll) start_poll = 1'b0;
        if (buttons_valid) edges.push_back(cyc);
        if (!issued && edges.size() == 2 && busy) begin
          start_poll = 1'b1;
          issued = 1'b1;
        end
      end
      check_eq("auto_count", edges.size(), 5);
      check_eq("auto_issued", issued, 1);
      for (int i = 1; i < edges.size(); i++) check_eq("auto_period", edges[i] - edges[i-1], 100);
      check_eq("auto_btn1", controller_1_buttons_out, 8'h81);
      check_eq("auto_btn2", controller_2_buttons_out, 8'h5A);
    end
`else
    // Idle: no latch or clock activity without a request.
    lat_seen = 0; clk_seen = 0;
    for (int k = 0; k < 100; k++) begin
      @(posedge clk_1); #1;
      if (controller_latch) lat_seen++;
      if (controller_clk_in) clk_seen++;
    end
    check_eq("idle_latch", lat_seen, 0);
    check_eq("idle_clk", clk_seen, 0);
    check_eq("idle_busy", busy, 0);

    // Single poll: pad 1 = A + Right, pad 2 = nothing.
    pad1_btn = 8'((1 << BTN_A) | (1 << BTN_RIGHT));
    pad2_btn = 8'h00;
    run_poll(0, ve, vc, lc, cp, ch, bf);
    check_eq("p1_valid_edge", ve, 33);
    check_eq("p1_valid_cnt", vc, 1);
    check_eq("p1_latch_cyc", lc, 2);
    check_eq("p1_clk_pulses", cp, 7);
    check_eq("p1_clk_high", ch, 14);
    check_eq("p1_busy_first", bf, 1);
    check_eq("p1_btn1", controller_1_buttons_out, 8'h81);
    check_eq("p1_btn2", controller_2_buttons_out, 8'h00);

    // Second request at edge 10 is ignored.
    run_poll(10, ve, vc, lc, cp, ch, bf);
    check_eq("ign_valid_edge", ve, 33);
    check_eq("ign_valid_cnt", vc, 1);
    check_eq("ign_latch_cyc", lc, 2);
    check_eq("ign_clk_pulses", cp, 7);
    check_eq("ign_btn1", controller_1_buttons_out, 8'h81);
    check_eq("ign_btn2", controller_2_buttons_out, 8'h00);

    // Abort mid-poll with reset.
    pad1_btn = 8'hFF;
    pad2_btn = 8'((1 << BTN_B) | (1 << BTN_START) | (1 << BTN_UP) | (1 << BTN_LEFT));
    start_poll = 1'b1;
    @(posedge clk_1); #1;
    start_poll = 1'b0;
    repeat (19) @(posedge clk_1);
    #1;
    check_eq("abort_busy_before", busy, 1);
    @(posedge clk_1);
    #1 rst = 1'b1;
    #1;
    check_eq("abort_busy", busy, 0);
    check_eq("abort_en", controller_clk_out_enable, 0);
    check_eq("abort_latch", controller_latch, 0);
    check_eq("abort_clk", controller_clk_in, 0);
    check_eq("abort_btn1", controller_1_buttons_out, 0);
    check_eq("abort_btn2", controller_2_buttons_out, 0);
    @(posedge clk_1); #1;
    rst = 1'b0;
    @(posedge clk_1); #1;
    run_poll(0, ve, vc, lc, cp, ch, bf);
    check_eq("post_abort_valid_edge", ve, 33);
    check_eq("post_abort_btn1", controller_1_buttons_out, 8'hFF);
    check_eq("post_abort_btn2", controller_2_buttons_out, 8'h5A);

    // Hold between polls, then pick up new values.
    pad1_btn = 8'((1 << BTN_SELECT) | (1 << BTN_START) | (1 << BTN_UP) | (1 << BTN_DOWN));
    pad2_btn = 8'((1 << BTN_A) | (1 << BTN_B) | (1 << BTN_LEFT) | (1 << BTN_RIGHT));
    repeat (20) @(posedge clk_1);
    #1;
    check_eq("hold_btn1", controller_1_buttons_out, 8'hFF);
    check_eq("hold_btn2", controller_2_buttons_out, 8'h5A);
    run_poll(0, ve, vc, lc, cp, ch, bf);
    check_eq("new_btn1", controller_1_buttons_out, 8'h3C);
    check_eq("new_btn2", controller_2_buttons_out, 8'hC3);

    // Disconnected pads read all 1s.
    pads_connected = 1'b0;
    run_poll(0, ve, vc, lc, cp, ch, bf);
    check_eq("disc_valid_cnt", vc, 1);
    check_eq("disc_btn1", controller_1_buttons_out, 8'h00);
    check_eq("disc_btn2", controller_2_buttons_out, 8'h00);
`endif

    $display("[TB] %0d tests run, %0d failed", checks, fails);
    $finish;
  end

endmodule
